dma_burst_sequencer: RTL and testbench

Consumes the DMA descriptor (memory address, LBA, sector count, direction, start pulse) published by the DMA register block. It splits the transfer into device-command chunks of at most MAX_SECTORS sectors. For each chunk it issues one device command, then 128-byte memory burst requests, 4 per 512-byte sector. It returns a single completion pulse with error status to the register block. It sits between the register block and the host-memory/device datapath, entirely in the sclk domain.

---
 rtl/dma_burst_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_dma_burst_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_sequencer.sv
// dma_burst_sequencer
//   Splits a DMA descriptor into device-command chunks of at most MAX_SECTORS sectors. For each
//   chunk it issues one device command, then four 128-byte memory bursts per 512-byte sector.
//   It returns one completion pulse with error status. All logic is in the sclk domain.
//
// Optional feature: define DMA_SEQ_TIMEOUT_EN to enable a WAIT-state watchdog that aborts
// with an error after TIMEOUT_CYCLES cycles without dev_done.
//
// Ports
//   i_sclk, i_rst_n            clock, synchronous active-low reset
//   i_dma_start                single-cycle start pulse (ignored unless idle)
//   i_mem_address [31:7]       host buffer address, 128-byte aligned
//   i_lba, i_sector_cnt        first LBA, number of sectors to move
//   i_dma_type                 1 = memory->device, 0 = device->memory
//   o_dma_done, o_dma_error    completion pulse, error status (held until next start)
//   o_dma_busy                 high in every state except idle
//   o_cmd_*, i_cmd_rdy         device command handshake (lba, count, direction)
//   o_burst_*, i_burst_rdy     memory burst handshake (address, direction, last-of-chunk)
//   i_dev_done, i_dev_err      chunk finished / device or datapath error pulses
module dma_burst_sequencer #(
   parameter int unsigned MAX_SECTORS    = 256,
   parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
   input  logic        i_sclk,
   input  logic        i_rst_n,
   input  logic        i_dma_start,
   input  logic [31:7] i_mem_address,
   input  logic [31:0] i_lba,
   input  logic [31:0] i_sector_cnt,
   input  logic        i_dma_type,
   output logic        o_dma_done,
   output logic        o_dma_error,
   output logic        o_dma_busy,
   output logic        o_cmd_val,
   input  logic        i_cmd_rdy,
   output logic [31:0] o_cmd_lba,
   output logic [15:0] o_cmd_cnt,
   output logic        o_cmd_dir,
   output logic        o_burst_val,
   input  logic        i_burst_rdy,
   output logic [31:7] o_burst_addr,
   output logic        o_burst_dir,
   output logic        o_burst_last,
   input  logic        i_dev_done,
   input  logic        i_dev_err
);

   typedef enum logic [2:0] {StIdle, StCmd, StBurst, StWait, StDone} state_e;

   state_e      r_state;
   state_e      w_state_d;
   logic [31:7] r_addr;
   logic [31:0] r_lba;
   logic [31:0] r_remaining;
   logic [15:0] r_chunk;
   logic [17:0] r_burst_cnt;
   logic        r_dir;
   logic        r_flag;
   logic        r_error;

   logic        w_cmd_fire;
   logic        w_burst_fire;
   logic        w_abort;
   logic        w_wait_go;
   logic        w_timeout;
   logic [31:0] w_chunk_src;
   logic [15:0] w_chunk;

   assign w_cmd_fire   = (r_state == StCmd) & i_cmd_rdy;
   assign w_burst_fire = (r_state == StBurst) & i_burst_rdy;
   assign w_abort      = i_dev_err & ((r_state == StCmd) | (r_state == StBurst) |
                                      (r_state == StWait));
   // The flag records a dev_done that arrived before the chunk's bursts were all issued.
   assign w_wait_go    = (r_state == StWait) & (i_dev_done | r_flag);

   // Chunk size is taken from the descriptor on start and from the remainder on re-entry.
   assign w_chunk_src  = (r_state == StIdle) ? i_sector_cnt : r_remaining;
   assign w_chunk      = (w_chunk_src > 32'(MAX_SECTORS)) ? 16'(MAX_SECTORS) : w_chunk_src[15:0];

`ifdef DMA_SEQ_TIMEOUT_EN
   logic [31:0] r_wait_cnt;

   // Counts WAIT cycles; zero in the first WAIT cycle.
   always_ff @(posedge i_sclk) begin
      if (!i_rst_n) begin
         r_wait_cnt <= '0;
      end else if (r_state != StWait) begin
         r_wait_cnt <= '0;
      end else begin
         r_wait_cnt <= r_wait_cnt + 32'd1;
      end
   end

   assign w_timeout = (r_state == StWait) & (r_wait_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge i_sclk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic; error abort beats dev_done, dev_done beats timeout.
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle: begin
            if (i_dma_start) w_state_d = (i_sector_cnt == '0) ? StDone : StCmd;
         end
         StCmd: begin
            if (w_abort)        w_state_d = StDone;
            else if (i_cmd_rdy) w_state_d = StBurst;
         end
         StBurst: begin
            if (w_abort)                                   w_state_d = StDone;
            else if (i_burst_rdy && r_burst_cnt == 18'd1) w_state_d = StWait;
         end
         StWait: begin
            if (w_abort)        w_state_d = StDone;
            else if (w_wait_go) w_state_d = (r_remaining == '0) ? StDone : StCmd;
            else if (w_timeout) w_state_d = StDone;
         end
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Descriptor, chunk and burst bookkeeping
   always_ff @(posedge i_sclk) begin
      if (!i_rst_n) begin
         r_addr      <= '0;
         r_lba       <= '0;
         r_remaining <= '0;
         r_chunk     <= '0;
         r_burst_cnt <= '0;
         r_dir       <= 1'b0;
         r_flag      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         if (r_state == StIdle && i_dma_start) begin
            r_error <= 1'b0;
            r_flag  <= 1'b0;
            if (i_sector_cnt != '0) begin
               r_addr      <= i_mem_address;
               r_lba       <= i_lba;
               r_remaining <= i_sector_cnt;
               r_dir       <= i_dma_type;
            end
         end
         if (w_state_d == StCmd && r_state != StCmd) begin
            r_chunk <= w_chunk;
         end
         if (w_cmd_fire) begin
            r_remaining <= r_remaining - 32'(r_chunk);
            r_lba       <= r_lba + 32'(r_chunk);
            r_burst_cnt <= {r_chunk, 2'b00};
         end
         if (w_burst_fire) begin
            r_addr      <= r_addr + 25'd1;
            r_burst_cnt <= r_burst_cnt - 18'd1;
         end
         if ((r_state == StCmd || r_state == StBurst) && i_dev_done) begin
            r_flag <= 1'b1;
         end else if (r_state == StWait && w_state_d != StWait) begin
            r_flag <= 1'b0;
         end
         if (w_abort || (w_timeout && !w_wait_go)) begin
            r_error <= 1'b1;
         end
      end
   end

   // Outputs
   always_comb begin
      o_dma_done   = (r_state == StDone);
      o_dma_busy   = (r_state != StIdle);
      o_cmd_val    = (r_state == StCmd);
      o_burst_val  = (r_state == StBurst);
      o_burst_last = (r_state == StBurst) && (r_burst_cnt == 18'd1);
      o_dma_error  = r_error;
      o_cmd_lba    = r_lba;
      o_cmd_cnt    = r_chunk;
      o_cmd_dir    = r_dir;
      o_burst_addr = r_addr;
      o_burst_dir  = r_dir;
   end

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Bench for dma_burst_sequencer (MAX_SECTORS=2, TIMEOUT_CYCLES=100). Expected commands and
// burst addresses come from a queue-based model of the chunking rules.
module tb_dma_burst_sequencer;

   localparam int unsigned MAX = 2;

   logic        clk;
   logic        rst_n;
   logic        i_dma_start;
   logic [24:0] i_mem_address;
   logic [31:0] i_lba;
   logic [31:0] i_sector_cnt;
   logic        i_dma_type;
   logic        o_dma_done;
   logic        o_dma_error;
   logic        o_dma_busy;
   logic        o_cmd_val;
   logic        i_cmd_rdy;
   logic [31:0] o_cmd_lba;
   logic [15:0] o_cmd_cnt;
   logic        o_cmd_dir;
   logic        o_burst_val;
   logic        i_burst_rdy;
   logic [24:0] o_burst_addr;
   logic        o_burst_dir;
   logic        o_burst_last;
   logic        i_dev_done;
   logic        i_dev_err;

   int n_vec = 0;
   int n_bad = 0;

   dma_burst_sequencer #(
      .MAX_SECTORS   (MAX),
      .TIMEOUT_CYCLES(100)
   ) u_dut (
      .i_sclk       (clk),
      .i_rst_n      (rst_n),
      .i_dma_start  (i_dma_start),
      .i_mem_address(i_mem_address),
      .i_lba        (i_lba),
      .i_sector_cnt (i_sector_cnt),
      .i_dma_type   (i_dma_type),
      .o_dma_done   (o_dma_done),
      .o_dma_error  (o_dma_error),
      .o_dma_busy   (o_dma_busy),
      .o_cmd_val    (o_cmd_val),
      .i_cmd_rdy    (i_cmd_rdy),
      .o_cmd_lba    (o_cmd_lba),
      .o_cmd_cnt    (o_cmd_cnt),
      .o_cmd_dir    (o_cmd_dir),
      .o_burst_val  (o_burst_val),
      .i_burst_rdy  (i_burst_rdy),
      .o_burst_addr (o_burst_addr),
      .o_burst_dir  (o_burst_dir),
      .o_burst_last (o_burst_last),
      .i_dev_done   (i_dev_done),
      .i_dev_err    (i_dev_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [24:0] addr;
      logic [31:0] lba;
      logic [31:0] cnt;
      logic        dir;
      bit          toggle;
      bit          early;
      bit          ign;
      int          n_cmd;
      int          n_burst;
      logic [24:0] last_addr;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one nonzero-count transfer and checks every handshake against the model.
   task automatic run_xfer(input logic [24:0] a, input logic [31:0] l, input logic [31:0] n,
                           input logic d, input bit toggle, input bit early, input bit ign,
                           output int ncmd, output int nburst, output logic [24:0] last_a,
                           output logic err);
      logic [31:0] q_lba[$];
      logic [15:0] q_cnt[$];
      logic [24:0] q_addr[$];
      bit          q_last[$];
      logic [31:0] rem;
      logic [31:0] lb;
      int unsigned c;
      int          idx;
      int          cyc;
      int          p_cyc;
      int          m_cyc;
      int          dly;
      bit          pend;
      bit          after_cmd;
      bit          stalled;
      bit          first_in_chunk;
      bit          done_seen;
      logic [24:0] held;

      rem = n;
      lb  = l;
      idx = 0;
      while (rem != 0) begin
         c = (rem > MAX) ? MAX : rem;
         q_lba.push_back(lb);
         q_cnt.push_back(c[15:0]);
         for (int s = 0; s < 4 * int'(c); s++) begin
            q_addr.push_back(a + 25'(idx));
            q_last.push_back(s == 4 * int'(c) - 1);
            idx++;
         end
         lb  = lb + c;
         rem = rem - c;
      end

      @(negedge clk);
      i_dma_start   = 1'b1;
      i_mem_address = a;
      i_lba         = l;
      i_sector_cnt  = n;
      i_dma_type    = d;
      @(negedge clk);
      i_dma_start = 1'b0;
      if (ign) begin
         i_mem_address = ~a;
         i_lba         = ~l;
         i_sector_cnt  = n + 3;
         i_dma_type    = ~d;
      end
      check("start_to_cmd_val", {31'd0, o_cmd_val}, 32'd1);
      check("error_cleared_on_start", {31'd0, o_dma_error}, 32'd0);

      ncmd = 0; nburst = 0; last_a = '0; err = 1'b0;
      cyc = 0; p_cyc = 0; m_cyc = 0; dly = 0;
      pend = 0; after_cmd = 0; stalled = 0; first_in_chunk = 1; done_seen = 0;
      while (!done_seen && cyc < 3000) begin
         i_dev_done  = 1'b0;
         i_cmd_rdy   = 1'b0;
         i_burst_rdy = 1'b0;
         i_dma_start = ign && (cyc == 3);
         if (o_dma_done) begin
            done_seen = 1;
            err       = o_dma_error;
            if (pend) check("wait_to_done", cyc - p_cyc, early ? 2 : 2 + dly);
         end else begin
            if (o_cmd_val) begin
               if (pend) begin
                  check("wait_to_cmd", cyc - p_cyc, early ? 2 : 2 + dly);
                  pend = 0;
               end
               i_cmd_rdy = ($urandom_range(0, 3) != 0);
               if (i_cmd_rdy) begin
                  if (ncmd < q_lba.size()) begin
                     check("cmd_lba", o_cmd_lba, q_lba[ncmd]);
                     check("cmd_cnt", {16'd0, o_cmd_cnt}, {16'd0, q_cnt[ncmd]});
                     check("cmd_dir", {31'd0, o_cmd_dir}, {31'd0, d});
                  end else begin
                     check("extra_cmd", ncmd, q_lba.size());
                  end
                  ncmd++;
                  m_cyc = cyc;
                  after_cmd = 1;
                  first_in_chunk = 1;
                  stalled = 0;
               end
            end
            if (o_burst_val) begin
               if (after_cmd) begin
                  check("cmd_to_burst", cyc - m_cyc, 1);
                  after_cmd = 0;
               end
               if (stalled) check("burst_addr_held", {7'd0, o_burst_addr}, {7'd0, held});
               i_burst_rdy = toggle ? cyc[0] : ($urandom_range(0, 3) != 0);
               if (early && first_in_chunk) begin
                  i_dev_done = 1'b1;
                  first_in_chunk = 0;
               end
               if (i_burst_rdy) begin
                  stalled = 0;
                  if (nburst < q_addr.size()) begin
                     check("burst_addr", {7'd0, o_burst_addr}, {7'd0, q_addr[nburst]});
                     check("burst_last", {31'd0, o_burst_last}, {31'd0, q_last[nburst]});
                     check("burst_dir", {31'd0, o_burst_dir}, {31'd0, d});
                     if (q_last[nburst]) begin
                        pend  = 1;
                        p_cyc = cyc;
                        dly   = early ? 0 : int'($urandom_range(0, 2));
                     end
                  end else begin
                     check("extra_burst", nburst, q_addr.size());
                  end
                  last_a = o_burst_addr;
                  nburst++;
               end else begin
                  stalled = 1;
                  held = o_burst_addr;
               end
            end
            if (pend && !early && cyc == p_cyc + 1 + dly) i_dev_done = 1'b1;
            @(negedge clk);
            cyc++;
         end
      end
      i_dma_start = 1'b0;
      i_dev_done  = 1'b0;
      i_cmd_rdy   = 1'b0;
      i_burst_rdy = 1'b0;
      check("done_within_budget", {31'd0, done_seen}, 32'd1);
      check("cmd_total", ncmd, q_lba.size());
      check("burst_total", nburst, q_addr.size());
      @(negedge clk);
      check("done_one_cycle", {30'd0, o_dma_done, o_dma_busy}, 32'd0);
   endtask

   vec_t        tbl[6];
   int          ncmd;
   int          nburst;
   logic [24:0] last_a;
   logic        err;
   int          cyc;
   int          p;
   bit          seen;
   logic [31:0] n;

   initial begin
      rst_n = 1'b0; i_dma_start = 1'b0; i_mem_address = '0; i_lba = '0; i_sector_cnt = '0;
      i_dma_type = 1'b0; i_cmd_rdy = 1'b0; i_burst_rdy = 1'b0; i_dev_done = 1'b0;
      i_dev_err = 1'b0;

      tbl[0] = '{25'h0000100, 32'h10,       32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8,  25'h0000107};
      tbl[1] = '{25'h0000040, 32'h1000,     32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3, 20, 25'h0000053};
      tbl[2] = '{25'h0000200, 32'h7,        32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 4,  25'h0000203};
      tbl[3] = '{25'h0000300, 32'h0,        32'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2, 12, 25'h000030B};
      tbl[4] = '{25'h1FFFFFF, 32'h5,        32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 4,  25'h0000002};
      tbl[5] = '{25'h0000000, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2, 12, 25'h000000B};

      repeat (2) @(negedge clk);
      check("reset_outputs", {24'd0, o_dma_done, o_dma_error, o_dma_busy, o_cmd_val,
            o_burst_val, o_burst_last, o_cmd_dir, o_burst_dir}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_xfer(tbl[i].addr, tbl[i].lba, tbl[i].cnt, tbl[i].dir, tbl[i].toggle, tbl[i].early,
                  tbl[i].ign, ncmd, nburst, last_a, err);
         check($sformatf("vec%0d_cmds", i), ncmd, tbl[i].n_cmd);
         check($sformatf("vec%0d_bursts", i), nburst, tbl[i].n_burst);
         check($sformatf("vec%0d_last_addr", i), {7'd0, last_a}, {7'd0, tbl[i].last_addr});
         check($sformatf("vec%0d_error", i), {31'd0, err}, 32'd0);
      end

      // Zero-count start: done next cycle, no command.
      @(negedge clk);
      i_dma_start = 1'b1; i_sector_cnt = 32'd0;
      @(negedge clk);
      i_dma_start = 1'b0;
      check("zero_done", {30'd0, o_dma_done, o_cmd_val}, 32'd2);
      check("zero_error", {31'd0, o_dma_error}, 32'd0);
      @(negedge clk);
      check("zero_idle", {30'd0, o_dma_done, o_dma_busy}, 32'd0);

      // dev_err mid-burst, together with dev_done: error wins.
      i_dma_start = 1'b1; i_mem_address = 25'h50; i_lba = 32'h20; i_sector_cnt = 32'd4;
      i_cmd_rdy = 1'b1; i_burst_rdy = 1'b1;
      @(negedge clk);
      i_dma_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("err_in_burst", {31'd0, o_burst_val}, 32'd1);
      i_dev_err = 1'b1; i_dev_done = 1'b1;
      @(negedge clk);
      i_dev_err = 1'b0; i_dev_done = 1'b0; i_cmd_rdy = 1'b0; i_burst_rdy = 1'b0;
      check("err_abort", {28'd0, o_cmd_val, o_burst_val, o_dma_done, o_dma_error}, 32'h3);
      @(negedge clk);
      check("err_held", {29'd0, o_dma_done, o_dma_busy, o_dma_error}, 32'h1);

      // Randomized transfers against the model.
      for (int i = 0; i < 10; i++) begin
         n = $urandom_range(1, 7);
         run_xfer(25'($urandom), $urandom, n, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                  ncmd, nburst, last_a, err);
         check("rand_cmds", ncmd, (n + MAX - 1) / MAX);
         check("rand_error", {31'd0, err}, 32'd0);
      end

      // Reset in CMD: outputs clear, no completion for the aborted transfer.
      @(negedge clk);
      i_dma_start = 1'b1; i_mem_address = 25'h77; i_lba = 32'hABCD; i_sector_cnt = 32'd3;
      i_dma_type = 1'b1;
      @(negedge clk);
      i_dma_start = 1'b0;
      check("rst_in_cmd", {31'd0, o_cmd_val}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_flags", {24'd0, o_dma_done, o_dma_error, o_dma_busy, o_cmd_val, o_burst_val,
            o_burst_last, o_cmd_dir, o_burst_dir}, 32'd0);
      check("rst_cmd_lba", o_cmd_lba, 32'd0);
      check("rst_cmd_cnt", {16'd0, o_cmd_cnt}, 32'd0);
      check("rst_burst_addr", {7'd0, o_burst_addr}, 32'd0);
      rst_n = 1'b1;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (o_dma_done || o_dma_busy) seen = 1;
      end
      check("rst_no_done", {31'd0, seen}, 32'd0);

      // No dev_done after the last burst.
      i_dma_start = 1'b1; i_mem_address = 25'h10; i_lba = 32'h99; i_sector_cnt = 32'd1;
      i_cmd_rdy = 1'b1; i_burst_rdy = 1'b1;
      @(negedge clk);
      i_dma_start = 1'b0;
      cyc = 0; p = -1;
      while (p < 0 && cyc < 50) begin
         if (o_burst_val && o_burst_last) p = cyc;
         @(negedge clk);
         cyc++;
      end
      i_cmd_rdy = 1'b0; i_burst_rdy = 1'b0;
      check("to_last_burst", {31'd0, p >= 0}, 32'd1);
`ifdef DMA_SEQ_TIMEOUT_EN
      cyc = 1;
      while (!o_dma_done && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("timeout_delay", cyc, 101);
      check("timeout_error", {31'd0, o_dma_error}, 32'd1);
`else
      seen = 0;
      repeat (1000) begin
         if (o_dma_done) seen = 1;
         @(negedge clk);
      end
      check("wait_no_done", {31'd0, seen}, 32'd0);
      check("wait_still_busy", {29'd0, o_dma_busy, o_cmd_val, o_burst_val}, 32'h4);
      do_reset();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
